// File: rtl/nes_video_pkg.sv
// nes_video_pkg: shared NES-to-VGA video constants and scheduler state type.
package nes_video_pkg;
    localparam int PIX_W     = 6;
    localparam int NES_W     = 256;
    localparam int NES_LINES = 240;
    localparam int H_LAST    = 799;
    localparam int V_LAST    = 524;
    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} sched_state_t;
endpackage

// File: rtl/scanline_scheduler_if.sv
// scanline_scheduler_if: render request and pixel return path between scheduler (master) and PPU (slave).
interface scanline_scheduler_if;
    import nes_video_pkg::*;
    logic             ppu_req;
    logic [7:0]       ppu_line;
    logic             ppu_ack;
    logic             ppu_pix_valid;
    logic [PIX_W-1:0] ppu_pix_data;
    modport master (output ppu_req, ppu_line, input ppu_ack, ppu_pix_valid, ppu_pix_data);
    modport slave (input ppu_req, ppu_line, output ppu_ack, ppu_pix_valid, ppu_pix_data);
endinterface

// File: rtl/line_buf_pp.sv
// line_buf_pp: two banks of one NES scanline each, one synchronous write port and one registered read port.
module line_buf_pp import nes_video_pkg::*; (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [7:0]       wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [7:0]       rd_addr,
    output logic [PIX_W-1:0] rd_data
);
    logic [PIX_W-1:0] mem [2][NES_W];

    always_ff @(posedge clk) begin
        if (we) mem[wr_bank][wr_addr] <= wr_data;
        rd_data <= mem[rd_bank][rd_addr];
    end
endmodule

// File: rtl/scanline_scheduler.sv
// scanline_scheduler: requests NES lines from the PPU into a back buffer and shows the front buffer 2x2-doubled on VGA.
module scanline_scheduler import nes_video_pkg::*; (
    input  logic                 vga_clk,
    input  logic                 Reset_n,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic                 h_blank,
    input  logic                 v_blank,
    scanline_scheduler_if.master ppu,
    output logic                 frame_start,
    output logic [PIX_W-1:0]     pix_out,
    output logic                 underrun
);
    sched_state_t state, state_n;
    logic [7:0] wr_ptr, disp_line, disp_n, line_q;
    logic front, blank_q, eol, swap_tick, pre_tick, tick, done_tick, we;
    logic [PIX_W-1:0] rd_data;

    assign eol = DrawX == 10'(H_LAST);
    // Swap ticks are ignored while idle so nothing is requested before the first pre_tick.
    assign swap_tick = eol && state != IDLE && (DrawY == 10'(V_LAST) || (DrawY[0] && DrawY < 10'd479));
    assign pre_tick = eol && DrawY == 10'd479;
    assign tick = swap_tick | pre_tick;
    assign done_tick = swap_tick && state == DONE;
    assign disp_n = DrawY == 10'(V_LAST) ? 8'd0 : disp_line + 8'd1;
    assign we = state == FILL && ppu.ppu_pix_valid && !tick;
    assign ppu.ppu_req = state == REQ;
    assign ppu.ppu_line = line_q;
    assign pix_out = blank_q ? '0 : rd_data;

    always_comb begin
        state_n = pre_tick ? REQ
                : swap_tick ? (disp_n < 8'(NES_LINES - 1) ? REQ : IDLE)
                : (state == REQ && ppu.ppu_ack) ? FILL
                : (we && &wr_ptr) ? DONE
                : state;
    end

    always_ff @(posedge vga_clk or negedge Reset_n)
        if (!Reset_n) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge vga_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr      <= 8'd0;
            front       <= 1'b0;
            disp_line   <= 8'd0;
            line_q      <= 8'd0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            blank_q     <= 1'b1;
        end else begin
            wr_ptr      <= state_n == FILL ? wr_ptr + 8'(we) : 8'd0;
            front       <= front ^ done_tick;
            disp_line   <= swap_tick ? disp_n : disp_line;
            line_q      <= pre_tick ? 8'd0 : swap_tick ? disp_n + 8'd1 : line_q;
            frame_start <= done_tick && disp_n == 8'd0;
            underrun    <= (swap_tick && state != DONE) || (underrun && !frame_start);
            blank_q     <= h_blank | v_blank;
        end
    end

    // The read bank is the registered front, so on a swap cycle it still points at the pre-swap bank.
    line_buf_pp u_buf (
        .clk    (vga_clk),
        .we     (we),
        .wr_bank(~front),
        .wr_addr(wr_ptr),
        .wr_data(ppu.ppu_pix_data),
        .rd_bank(front),
        .rd_addr(DrawX[8:1]),
        .rd_data(rd_data)
    );
endmodule

// File: tb/tb_scanline_scheduler.sv
// tb_scanline_scheduler: directed scan of fills, swaps, underruns, tick/ack collisions and async reset.
module tb_scanline_scheduler;
    import nes_video_pkg::*;

    logic clk = 1'b0, rst_n;
    logic [9:0] dx, dy;
    logic hb, vb, fs, ur;
    logic [PIX_W-1:0] pix;
    int vectors = 0, miscompares = 0;

    scanline_scheduler_if ppu();

    assign hb = dx >= 10'd512;
    assign vb = dy >= 10'd480;

    scanline_scheduler dut (
        .vga_clk    (clk),
        .Reset_n    (rst_n),
        .DrawX      (dx),
        .DrawY      (dy),
        .h_blank    (hb),
        .v_blank    (vb),
        .ppu        (ppu),
        .frame_start(fs),
        .pix_out    (pix),
        .underrun   (ur)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pat(input int l, input int x);
        return 6'((x + 3 * l) & 63);
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic go(input int x, input int y);
        dx = 10'(x);
        dy = 10'(y);
        clk1();
    endtask

    task automatic tick(input int y);
        dx = 10'd799;
        dy = 10'(y);
        clk1();
        dx = 10'd0;
    endtask

    task automatic fill(input int l, input int n);
        dx = 10'd0;
        ppu.ppu_ack = 1'b1;
        clk1();
        ppu.ppu_ack = 1'b0;
        for (int x = 0; x < n; x++) begin
            ppu.ppu_pix_valid = 1'b1;
            ppu.ppu_pix_data = pat(l, x);
            clk1();
        end
        ppu.ppu_pix_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        dx = 10'd0;
        dy = 10'd478;
        ppu.ppu_ack = 1'b0;
        ppu.ppu_pix_valid = 1'b0;
        ppu.ppu_pix_data = '0;
        repeat (2) clk1();
        chk("rst_req", ppu.ppu_req, 0);
        chk("rst_line", ppu.ppu_line, 0);
        chk("rst_fs", fs, 0);
        chk("rst_pix", pix, 0);
        chk("rst_ur", ur, 0);
        rst_n = 1'b1;
        tick(477);
        chk("idle_swap_req", ppu.ppu_req, 0);
        chk("idle_swap_ur", ur, 0);
        tick(479);
        chk("pre_req", ppu.ppu_req, 1);
        chk("pre_line", ppu.ppu_line, 0);
        fill(0, 256);
        chk("fill0_done_req", ppu.ppu_req, 0);
        tick(524);
        chk("f0_fs", fs, 1);
        chk("f0_req", ppu.ppu_req, 1);
        chk("f0_line", ppu.ppu_line, 1);
        clk1();
        chk("f0_fs_pulse", fs, 0);
        go(10, 0);
        chk("y0_x10", pix, 5);
        go(11, 0);
        chk("y0_x11", pix, 5);
        go(200, 0);
        chk("y0_x200", pix, 36);
        go(600, 0);
        chk("y0_hblank", pix, 0);
        go(10, 1);
        chk("y1_x10", pix, 5);
        for (int l = 1; l <= 4; l++) begin
            fill(l, 256);
            tick(2 * l - 1);
            chk("swap_line", ppu.ppu_line, 32'(l + 1));
            go(10, 2 * l);
            chk("swap_pix", pix, 32'(pat(l, 5)));
        end
        chk("pre_underrun_ur", ur, 0);
        fill(5, 100);
        tick(9);
        chk("ur_set", ur, 1);
        chk("ur_req", ppu.ppu_req, 1);
        chk("ur_line", ppu.ppu_line, 6);
        go(10, 10);
        chk("ur_repeat_y10", pix, 17);
        go(40, 11);
        chk("ur_repeat_y11", pix, 32);
        ppu.ppu_ack = 1'b1;
        tick(11);
        ppu.ppu_ack = 1'b0;
        chk("ackcol_req", ppu.ppu_req, 1);
        chk("ackcol_line", ppu.ppu_line, 7);
        ppu.ppu_pix_valid = 1'b1;
        repeat (5) clk1();
        ppu.ppu_pix_valid = 1'b0;
        chk("ackcol_no_fill", ppu.ppu_req, 1);
        fill(7, 256);
        tick(13);
        chk("l7_line", ppu.ppu_line, 8);
        chk("ur_sticky", ur, 1);
        go(10, 14);
        chk("l7_pix", pix, 26);
        for (int y = 15; y <= 475; y += 2) tick(y);
        chk("l239_req", ppu.ppu_req, 1);
        chk("l239_line", ppu.ppu_line, 239);
        fill(239, 256);
        tick(477);
        chk("end_req", ppu.ppu_req, 0);
        chk("end_state", 32'(dut.state), 32'(IDLE));
        go(10, 478);
        chk("l239_pix", pix, 18);
        tick(479);
        chk("pre2_req", ppu.ppu_req, 1);
        chk("pre2_line", ppu.ppu_line, 0);
        fill(0, 256);
        tick(524);
        chk("f1_fs", fs, 1);
        chk("f1_ur_held", ur, 1);
        clk1();
        chk("f1_ur_clear", ur, 0);
        fill(1, 50);
        tick(1);
        chk("ur2_set", ur, 1);
        chk("ur2_line", ppu.ppu_line, 2);
        go(10, 2);
        chk("ur2_pix", pix, 5);
        fill(2, 128);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_req", ppu.ppu_req, 0);
        chk("arst_pix", pix, 0);
        chk("arst_ur", ur, 0);
        chk("arst_state", 32'(dut.state), 32'(IDLE));
        #2 rst_n = 1'b1;
        ppu.ppu_pix_valid = 1'b1;
        repeat (4) clk1();
        ppu.ppu_pix_valid = 1'b0;
        chk("post_rst_state", 32'(dut.state), 32'(IDLE));
        chk("post_rst_req", ppu.ppu_req, 0);
        tick(479);
        chk("pre3_req", ppu.ppu_req, 1);
        fill(0, 256);
        chk("pre3_done", 32'(dut.state), 32'(DONE));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/scanline_scheduler.md
Name: scanline_scheduler

Overview:
- Sits between the PPU pixel pipeline and the 640x480 VGA timing counter.
- Owns a ping-pong pair of 256-entry scanline buffers.
- Issues per-line render requests to the PPU and captures the 256 pixels the PPU returns into the back buffer.
- Presents the front buffer to VGA with 2x horizontal and 2x vertical doubling: each NES line occupies VGA lines 2n and 2n+1, and each pixel is held for 2 clocks.

Parameters:
- PIX_W, 6, width of one pixel (NES palette index).
- H_LAST, 799, last horizontal count of a VGA line.
- V_LAST, 524, last vertical count of a VGA frame.
- NES_LINES, 240, number of NES scanlines per frame.

Ports:
- vga_clk  in  1  pixel clock, 25.175 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  horizontal count from the VGA timing block.
- DrawY  in  10  vertical count from the VGA timing block.
- h_blank  in  1  high when DrawX>=512.
- v_blank  in  1  high when DrawY>=480.
- ppu_req  out  1  render request, held until acknowledged.
- ppu_line  out  8  NES line number being requested; stable while ppu_req is high.
- ppu_ack  in  1  one-cycle accept of the request.
- ppu_pix_valid  in  1  ppu_pix_data is valid this cycle.
- ppu_pix_data  in  PIX_W  pixel, delivered in order x=0..255.
- frame_start  out  1  one-cycle pulse when the front buffer receives NES line 0.
- pix_out  out  PIX_W  pixel for the DrawX/DrawY of the previous cycle.
- underrun  out  1  sticky flag: a line was not complete at its swap tick.

Behaviour:
- Reset (Reset_n low, async):
  - state=IDLE, wr_ptr=0, front=0, disp_line=0.
  - Outputs: ppu_req=0, ppu_line=0, frame_start=0, pix_out=0, underrun=0.
  - Buffer contents are undefined after reset; they are not cleared.
- Ticks (all evaluated at DrawX==H_LAST):
  - swap_tick: DrawY==V_LAST, or (DrawY odd and DrawY<479).
  - pre_tick: DrawY==479.
- States:
  - IDLE: nothing pending.
  - REQ: ppu_req=1.
  - FILL: accepting pixels.
  - DONE: 256 pixels captured.
- Transitions:
  - REQ -> FILL when ppu_ack=1. wr_ptr=0 on entry to FILL.
  - FILL: each ppu_pix_valid writes back[wr_ptr] and increments wr_ptr. The write with wr_ptr==255 moves to DONE.
  - ppu_pix_valid is ignored outside FILL.
- swap_tick with state==DONE:
  - front<=~front.
  - disp_line<=next line: 0 at DrawY==V_LAST, else disp_line+1.
  - If the new disp_line+1 < NES_LINES: go to REQ with ppu_line=disp_line+1. Otherwise go to IDLE.
  - frame_start=1 for 1 cycle when the new disp_line==0.
- swap_tick with state!=DONE (underrun):
  - No swap; front keeps its old line, so that line is repeated.
  - underrun<=1.
  - disp_line still advances.
  - Any in-progress fill is aborted (wr_ptr<=0) and the FSM goes to REQ for the line that would normally follow.
- pre_tick: from any state, abort any fill and go to REQ with ppu_line=0.
- ppu_ack and a tick in the same cycle: the tick wins; the ack is discarded and ppu_req stays high for the new line.
- underrun clears only on the frame_start cycle. If an underrun occurs on that same tick, set wins.
- Read path, latency 1:
  - rd_addr = DrawX[8:1].
  - pix_out <= (h_blank|v_blank) ? 0 : front_buf[rd_addr].
- Buffer write and read never target the same bank in the same cycle, except on the swap cycle. On that cycle the read uses the pre-swap bank.
- After reset, the first request is issued at the first pre_tick. The display before the first frame_start shows undefined buffer contents; this is acceptable.

Decomposition:
- Package nes_video_pkg holds:
  - PIX_W, NES_W=256, NES_LINES=240, H_LAST, V_LAST.
  - sched_state_t enum {IDLE, REQ, FILL, DONE}.
- One sub-module, line_buf_pp: a 2x256xPIX_W array with a bank-select bit.
  - One synchronous write port: bank, addr, data, we.
  - One synchronous read port: bank, addr.
  - The scheduler FSM, ticks and read mux stay in scanline_scheduler.

Test Plan:
- Reset, then run to DrawY=479, DrawX=799.
  - Next cycle: ppu_req=1, ppu_line=0.
  - Ack, then stream 256 pixels of value x[5:0].
  - At the DrawY=524 tick: frame_start pulses, and ppu_req=1 with ppu_line=1.
- Line 0 loaded with x[5:0].
  - At DrawY=0, DrawX=10 and DrawX=11: pix_out one cycle later = 5 for both.
  - Same value at DrawY=1.
  - pix_out=0 at DrawX>=512.
- Withhold ppu_pix_valid after 100 pixels of line 5.
  - At the DrawY=9 tick: underrun=1, front still holds line 4 (repeated on DrawY 10-11).
  - ppu_line=6 on the next request.
  - underrun clears at the next frame_start.
- Assert ppu_ack in the same cycle as a swap_tick.
  - ppu_req stays high; ppu_line changes to the new value.
  - No pixels are accepted until a later ack.
- Deliver line 239 normally.
  - After the DrawY=477 tick: state=IDLE, ppu_req=0.
  - At the DrawY=479 tick: ppu_req=1, ppu_line=0.
- Drive Reset_n low mid-FILL at wr_ptr=128, asynchronously.
  - ppu_req, pix_out and underrun go to 0 immediately; state=IDLE.
  - Pixels arriving before the next ack are ignored.
